// File: rtl/led_pattern_seq.sv
// Tick-driven LED pattern sequencer: RUN, BOUNCE, COUNT and BLINK patterns with wrap pulse.
// Optional PWM dimming of the LED drive is enabled by defining LED_DIM_EN.
module led_pattern_seq #(
    parameter int N_LED    = 3,
    parameter int DIM_DUTY = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode_q,
    output logic             wrap
);

    typedef enum logic [1:0] {
        M_RUN    = 2'd0,
        M_BOUNCE = 2'd1,
        M_COUNT  = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    localparam logic [N_LED-1:0] PAT_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] PAT_MSB  = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] PAT_ONES = {N_LED{1'b1}};

    // Out-of-range parameters leave this empty block as a visible marker in the elaborated hierarchy.
    if (N_LED < 2 || N_LED > 8 || DIM_DUTY < 0 || DIM_DUTY > 15) begin : g_param_out_of_range
    end

    function automatic logic [N_LED-1:0] start_pat(input mode_t m);
        logic [N_LED-1:0] p;
        case (m)
            M_RUN:    p = PAT_ONE;
            M_BOUNCE: p = PAT_ONE;
            M_COUNT:  p = '0;
            M_BLINK:  p = PAT_ONES;
            default:  p = PAT_ONE;
        endcase
        return p;
    endfunction

    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] pat_nxt;
    logic             dir_up;
    logic             dir_up_nxt;
    mode_t            mode_r;
    mode_t            mode_nxt;
    logic             wrap_nxt;

    always_comb begin
        pat_nxt    = pat;
        dir_up_nxt = dir_up;
        mode_nxt   = mode_r;
        wrap_nxt   = 1'b0;
        if (tick) begin
            if (mode != mode_r) begin
                // A mode change reloads the start value and never counts as a wrap.
                mode_nxt   = mode_t'(mode);
                pat_nxt    = start_pat(mode_t'(mode));
                dir_up_nxt = 1'b1;
            end else if (!pause) begin
                case (mode_r)
                    M_RUN:   pat_nxt = {pat[N_LED-2:0], pat[N_LED-1]};
                    M_BOUNCE: begin
                        if (dir_up) begin
                            pat_nxt = pat << 1;
                            if (pat_nxt == PAT_MSB) dir_up_nxt = 1'b0;
                        end else begin
                            pat_nxt = pat >> 1;
                            if (pat_nxt == PAT_ONE) dir_up_nxt = 1'b1;
                        end
                    end
                    M_COUNT: pat_nxt = pat + PAT_ONE;
                    M_BLINK: pat_nxt = ~pat;
                    default: pat_nxt = pat;
                endcase
                wrap_nxt = (pat_nxt == start_pat(mode_r));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat    <= PAT_ONE;
            dir_up <= 1'b1;
            mode_r <= M_RUN;
            wrap   <= 1'b0;
        end else begin
            pat    <= pat_nxt;
            dir_up <= dir_up_nxt;
            mode_r <= mode_nxt;
            wrap   <= wrap_nxt;
        end
    end

    assign mode_q = mode_r;

`ifdef LED_DIM_EN
    localparam logic [3:0] DIM_ON = 4'(DIM_DUTY);

    logic [3:0] dim_cnt;

    // The LED is gated by the counter value present before the edge, so DIM_DUTY cycles out of 16 are lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            dim_cnt <= 4'd0;
            led     <= PAT_ONE;
        end else begin
            dim_cnt <= dim_cnt + 4'd1;
            led     <= (dim_cnt < DIM_ON) ? pat_nxt : '0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) led <= PAT_ONE;
        else       led <= pat_nxt;
    end
`endif

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Downstream consumer of the clock-divider stage: takes the divider's single-cycle enable pulse `tick` and steps an LED pattern once per tick.
- Four selectable patterns: running light, ping-pong, binary count, blink.
- Single clock domain.
- Drives the board LEDs and reports a wrap pulse for higher-level sequencing.

Parameters:
N_LED, 3, number of LEDs / pattern width; legal range 2..8.
DIM_DUTY, 8, PWM on-count out of 16 (0..15); used only when LED_DIM_EN is defined.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset; takes priority over all other inputs.
tick  input  1  step enable from the divider, one clk cycle wide; back-to-back highs are legal.
mode  input  2  pattern select: 0 RUN, 1 BOUNCE, 2 COUNT, 3 BLINK.
pause  input  1  when high, pattern does not advance; mode changes are still accepted.
led  output  N_LED  registered LED drive, active-high.
mode_q  output  2  currently applied mode.
wrap  output  1  one-cycle pulse when the pattern returns to its start value.

Behaviour:
- Reset (edge with reset=1):
  - pat=1 (LSB one-hot); dir=up; mode_q=0; wrap=0; led=1; dim counter=0.
  - Reset asserted mid-sequence overrides any tick in the same cycle.
- Only edges with tick=1 can change pat, dir or mode_q. With tick=0, pat, dir and mode_q hold and wrap=0.
- Mode change: edge where tick=1 and mode≠mode_q, regardless of pause:
  - mode_q<=mode.
  - pat<=start value of the new mode; dir<=up.
  - wrap=0; no advance on that tick.
- Start values: RUN = 1; BOUNCE = 1; COUNT = 0; BLINK = all ones.
- Advance occurs on an edge with tick=1, pause=0 and mode==mode_q:
  - RUN: rotate left by 1; MSB wraps to LSB. wrap=1 when next pat==1.
  - BOUNCE: shift left while dir=up, shift right while dir=down.
    - dir flips to down on the edge pat becomes the MSB one-hot.
    - dir flips to up on the edge pat becomes 1.
    - wrap=1 when next pat==1.
    - N_LED=3 sequence: 001,010,100,010,001,010…
  - COUNT: pat<=pat+1 modulo 2^N_LED. wrap=1 when next pat==0.
  - BLINK: pat<=~pat. wrap=1 when next pat==all ones.
- Paused tick (tick=1, pause=1, mode==mode_q): no change; wrap=0.
- wrap is registered and asserted exactly on the edge that loads the start value by advance, for one cycle. A mode-change load never raises wrap.
- Latency: led<=next pat on the same edge that samples tick=1, so the new pattern is visible the cycle after tick. mode_q also updates on that edge.
- Widths: all pattern arithmetic is N_LED bits and discards the carry.

Optional Feature:
- Macro: LED_DIM_EN.
- Defined:
  - A 4-bit free-running dim counter increments every clk and resets to 0.
  - led = pat when counter < DIM_DUTY, else 0, registered.
  - DIM_DUTY=0 gives led constantly 0.
  - pat, wrap and mode_q timing are unchanged.
- Undefined: no counter; led = pat exactly as above; DIM_DUTY is ignored.

Test Plan:
1. Reset, RUN, N_LED=3, pause=0, tick every 4 clk:
   - Expect led sequence 001→010→100→001.
   - Expect wrap high for one cycle on the 3rd tick only.
2. mode=1 (BOUNCE) applied at a tick:
   - Expect mode_q=1 and led=001 with no wrap on that tick.
   - Next 4 ticks give 010,100,010,001; wrap on the 4th.
3. mode=2 (COUNT), tick high 8 consecutive cycles:
   - Expect led 000 after the mode-change tick.
   - Then led 001…111 for the next 7 ticks.
   - One further tick gives 000 with wrap=1.
4. mode=3 (BLINK), pause=1 across 3 ticks:
   - Expect led stays 111 and wrap=0.
   - Release pause: next tick gives 000, following tick gives 111 with wrap=1.
5. Mode changed with tick=0:
   - Expect mode_q unchanged until the next tick.
   - Assert reset on the same cycle as a tick: expect led=001, mode_q=0, wrap=0.
6. LED_DIM_EN defined, DIM_DUTY=4, RUN with led=001:
   - Over 16 clk, led[0] is high for exactly 4 cycles (counter 0..3), low for 12.
   - With DIM_DUTY=0, led is always 000.
